// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store memory stage.
// Covers funct3 encodings, FSM states, error codes and access-legality helpers.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Single-outstanding req/gnt/rvalid data-memory port.
// The LSU is the master; the memory (or bench model) is the slave.
interface lsu_mem_stage_if #(parameter int WIDTH = 32);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_wstrb;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store stage: checks the access, runs one memory transaction with a
// bus timeout and returns extended load data or store completion to writeback.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [WIDTH-1:0]  in_addr,
  input  logic [WIDTH-1:0]  in_wdata,
  input  logic [4:0]        in_rd,
  lsu_mem_stage_if.master   mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic              out_err,
  output logic [1:0]        out_err_code
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // state | meaning
  // IDLE  | ready for a new access
  // REQ   | mem_req high, waiting for mem_gnt
  // WAIT  | load granted, waiting for mem_rvalid
  // RESP  | result presented until out_ready
  lsu_state_t       r_state, w_next;
  logic             r_store;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_addr;
  logic [4:0]       r_rd;
  logic [3:0]       r_wstrb;
  logic [WIDTH-1:0] r_wdata;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_we;
  lsu_err_t         r_err_code;

  lsu_err_t         w_code;
  logic [3:0]       w_wstrb;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_load_data;
  logic             w_tc;

  assign w_tc = (r_cnt == TO_LAST);

  always_comb begin
    if (!f3_legal(in_store, in_funct3))
      w_code = ERR_FUNCT3;
    else if (f3_misaligned(in_funct3, in_addr[1:0]))
      w_code = ERR_MISALIGN;
    else
      w_code = ERR_NONE;
  end

  // Lanes are computed at accept so the bus fields come straight from flops.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = in_wdata;
    case (in_funct3)
      F3_B: begin
        w_wstrb = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      F3_H: begin
        w_wstrb = 4'b0011 << in_addr[1:0];
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!in_store) w_wstrb = 4'b0000;
  end

  lsu_load_align u_load_align (
    .i_rdata  (mem.mem_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    mem.mem_req  = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (w_code == ERR_NONE) ? ST_REQ : ST_RESP;
      end
      ST_REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_gnt) w_next = r_store ? ST_RESP : ST_WAIT;
        else if (w_tc)   w_next = ST_RESP;
      end
      ST_WAIT: begin
        if (mem.mem_rvalid || w_tc) w_next = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) && ((w_next == ST_REQ) || (w_next == ST_WAIT))) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_store    <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_rd       <= 5'd0;
      r_wstrb    <= 4'd0;
      r_wdata    <= '0;
      r_out_data <= '0;
      r_out_we   <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_store    <= in_store;
          r_funct3   <= in_funct3;
          r_addr     <= in_addr;
          r_rd       <= in_rd;
          r_wstrb    <= w_wstrb;
          r_wdata    <= w_wdata;
          r_out_data <= '0;
          r_out_we   <= 1'b0;
          r_err_code <= w_code;
        end
        ST_REQ: if (!mem.mem_gnt && w_tc) r_err_code <= ERR_TIMEOUT;
        ST_WAIT: begin
          if (mem.mem_rvalid) begin
            r_out_data <= w_load_data;
            r_out_we   <= 1'b1;
          end else if (w_tc) begin
            r_err_code <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_we    = r_store;
  assign mem.mem_addr  = {r_addr[WIDTH-1:2], 2'b00};
  assign mem.mem_wstrb = r_wstrb;
  assign mem.mem_wdata = r_wdata;

  assign out_data     = r_out_data;
  assign out_rd       = r_rd;
  assign out_we       = r_out_we;
  assign out_err      = (r_err_code != ERR_NONE);
  assign out_err_code = r_err_code;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly downstream of the RV32I ALU in the execute/memory path.
- Takes the ALU result as the effective address, plus store data and access type.
- Drives a single-outstanding request/grant/rvalid data-memory port.
- Returns aligned, sign/zero-extended load data or store completion to writeback, with misalignment and bus-timeout error reporting.

Parameters:
- width, 32, data and address width (RV32I; only 32 supported).
- timeout, 255, max cycles waiting for mem_gnt or mem_rvalid before a bus-timeout error; 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_store  in  1  1 = store, 0 = load.
- in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- in_addr  in  width  effective address (ALU out_alu).
- in_wdata  in  width  store data (rs2).
- in_rd  in  5  destination register tag.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  width  word-aligned address {in_addr[31:2],2'b00}.
- mem_wstrb  out  4  byte-lane write strobes.
- mem_wdata  out  width  lane-replicated store data.
- mem_gnt  in  1  request accepted by memory.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  width  load word.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts result.
- out_data  out  width  extended load value; 0 for stores and errors.
- out_rd  out  5  captured rd.
- out_we  out  1  1 only for a successful load.
- out_err  out  1  error flag.
- out_err_code  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: state IDLE. All outputs 0 except in_ready=1. Timeout counter 0.
- Reset mid-transaction abandons it. mem_req and out_valid are low the cycle after the reset edge. No response is produced.
- IDLE: in_ready=1. On accept, capture store flag, funct3, addr, wdata and rd into registers.
  - Illegal funct3 (load 011/110/111; store other than 000/001/010) -> RESP, code 10.
  - Misaligned access -> RESP, code 01. Misaligned means H/HU/SH with addr[0]=1, or W with addr[1:0]!=0.
  - Otherwise -> REQ.
- REQ: mem_req=1. mem_we/mem_addr/mem_wstrb/mem_wdata are driven from registers and held stable until mem_gnt.
  - On mem_gnt: store -> RESP; load -> WAIT.
  - mem_rvalid in the same cycle as mem_gnt is ignored; the memory returns data at least one cycle after gnt.
- WAIT: mem_req=0. On mem_rvalid, capture the extracted data -> RESP.
- Timeout: the counter clears on entry to REQ and to WAIT and increments each cycle in those states. Reaching timeout without gnt/rvalid -> RESP, code 11, mem_req drops.
- RESP: out_valid=1 with stable outputs until out_ready, then IDLE. in_ready=0 in all states except IDLE. Best-case latency is accept->out_valid = 2 cycles for a store and 3 for a load, with same-cycle gnt/rvalid from memory.
- Store lanes (off=addr[1:0]):
  - SB: wstrb=4'b0001<<off, wdata={4{rs2[7:0]}}.
  - SH: wstrb=4'b0011<<off, wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'b1111.
- Load extract: byte = rdata[8*off+:8]; half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- rd=0 loads still access memory; out_we=1 and out_rd=0; writeback discards the value.
- out_data is 0 and out_we is 0 whenever out_err=1.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - error codes (ERR_NONE, ERR_MISALIGN, ERR_FUNCT3, ERR_TIMEOUT).
- One combinational sub-module, lsu_load_align: inputs rdata, off[1:0], funct3; output is the 32-bit extended value. Store lane/strobe generation stays inline.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234, gnt and rvalid one cycle each -> out_data=0xFFFF_FF80, out_we=1, out_err=0.
- LHU addr=0x1002, rdata=0x8001_0000 -> out_data=0x0000_8001. LH at the same address -> 0xFFFF_8001.
- SB addr=0x2001, rs2=0x0000_00AB -> mem_wstrb=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x2000. out_valid with out_we=0.
- LW addr=0x3002 -> no mem_req ever asserted, out_err=1, code 01. Load funct3=011 -> code 10.
- Load with mem_gnt held low and timeout=4 -> mem_req for exactly 4 cycles, then out_err code 11. The next request is accepted normally.
- Load with gnt given, then rst asserted in WAIT -> next cycle: IDLE, in_ready=1, out_valid=0. A late rvalid is ignored. A following SW completes correctly. out_ready held low 3 cycles -> outputs stable, in_ready=0 throughout.
